riscv_ahb_code_rom_slave: RTL and testbench

//  AHB-Lite responder (slave) for the core's instruction-fetch (code) bus; the target end of the code-bus master

---
 rtl/riscv_ahb_pkg.sv | 16 +
 rtl/riscv_ahb_code_rom_slave_if.sv | 27 ++
 rtl/riscv_code_rom.sv | 23 ++
 rtl/riscv_ahb_code_rom_slave.sv | 118 +++++++++++
 tb/tb_riscv_ahb_code_rom_slave.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ahb_pkg.sv
// Shared AHB-Lite encodings for the core's bus responders.
package riscv_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/riscv_ahb_code_rom_slave_if.sv
// AHB-Lite code-bus signals between the interconnect (master side) and the ROM responder.
interface riscv_ahb_code_rom_slave_if;
  // Handshake: an address phase is taken on an edge where hsel & hready & htrans[1]; its data phase
  // ends on the first later edge with hreadyout high, and hresp qualifies that completion.
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/riscv_code_rom.sv
// Instruction word store with a registered read port.
module riscv_code_rom #(
  parameter int    DEPTH     = 16384,
  parameter int    IDX_W     = 14,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             en,
  input  logic [IDX_W-1:0] addr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/riscv_ahb_code_rom_slave.sv
// AHB-Lite read-only responder for instruction fetch: sync ROM, programmable wait states, two-cycle ERROR.
module riscv_ahb_code_rom_slave
  import riscv_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_BYTES   = 65536,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                             clk,
  input  logic                             rst,
  riscv_ahb_code_rom_slave_if.slave        bus,
  output logic [2:0]                       state_dbg
);

  localparam int DEPTH = MEM_BYTES / 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        resp_q;
  logic        can_accept;
  logic        accept;
  logic        misaligned;
  logic        bad;
  logic        rom_en;
  logic [31:0] offset;
  logic [31:0] rom_rdata;
  logic        unused_ok;

  // Wrap below the base makes offset huge, so one unsigned compare covers both range ends.
  assign offset = bus.haddr - BASE_ADDR;

  always_comb begin
    misaligned = 1'b0;
    case (bus.hsize)
      HSIZE_HALF: misaligned = bus.haddr[0];
      HSIZE_WORD: misaligned = |bus.haddr[1:0];
      default:    misaligned = 1'b0;
    endcase
  end

  assign bad        = bus.hwrite | (bus.hsize > HSIZE_WORD) | misaligned | (offset >= 32'(MEM_BYTES));
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept & bus.hsel & bus.hready & bus.htrans[1];
  assign rom_en     = accept & ~bad;
  assign unused_ok  = ^{bus.hburst, bus.hprot, bus.hmastlock};

  riscv_code_rom #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk   (clk),
    .en    (rom_en),
    .addr  (offset[IDX_W+1:2]),
    .rdata (rom_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        default: begin
          if (accept && bad) begin
            state   <= S_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
          end else if (accept && (WAIT_STATES > 0)) begin
            state   <= S_WAIT;
            cnt     <= 4'(WAIT_STATES);
            ready_q <= 1'b0;
            resp_q  <= HRESP_OKAY;
          end else if (accept) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end else begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign bus.hreadyout = ready_q;
  assign bus.hresp     = resp_q;
  assign bus.hrdata    = (state == S_DATA) ? rom_rdata : '0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_riscv_ahb_code_rom_slave.sv
// Bench for the code ROM responder: three instances (0, 2 and 3 wait states), one active at a time.
module tb_riscv_ahb_code_rom_slave;
  import riscv_ahb_pkg::*;

  localparam int          MEM_BYTES = 256;
  localparam int          DEPTH     = MEM_BYTES / 4;
  localparam logic [31:0] BASE_A    = 32'h0000_0000;
  localparam logic [31:0] BASE_C    = 32'h0000_1000;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        hsel, hready, hwrite, hmastlock;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  int          sel;

  logic        o_ready, o_resp;
  logic [31:0] o_data;
  logic [2:0]  o_state, st0, st1, st2;

  logic [31:0] rom_model [DEPTH];
  logic [33:0] exp_q [$];
  int          n_checks, n_fail;
  logic        last_idle;

  riscv_ahb_code_rom_slave_if bus0 ();
  riscv_ahb_code_rom_slave_if bus1 ();
  riscv_ahb_code_rom_slave_if bus2 ();

  assign bus0.hsel = hsel & (sel == 0);
  assign bus1.hsel = hsel & (sel == 1);
  assign bus2.hsel = hsel & (sel == 2);
  assign bus0.haddr = haddr;   assign bus1.haddr = haddr;   assign bus2.haddr = haddr;
  assign bus0.htrans = htrans; assign bus1.htrans = htrans; assign bus2.htrans = htrans;
  assign bus0.hwrite = hwrite; assign bus1.hwrite = hwrite; assign bus2.hwrite = hwrite;
  assign bus0.hsize = hsize;   assign bus1.hsize = hsize;   assign bus2.hsize = hsize;
  assign bus0.hburst = hburst; assign bus1.hburst = hburst; assign bus2.hburst = hburst;
  assign bus0.hprot = hprot;   assign bus1.hprot = hprot;   assign bus2.hprot = hprot;
  assign bus0.hmastlock = hmastlock; assign bus1.hmastlock = hmastlock; assign bus2.hmastlock = hmastlock;
  assign bus0.hready = hready; assign bus1.hready = hready; assign bus2.hready = hready;

  riscv_ahb_code_rom_slave #(.BASE_ADDR(BASE_A), .MEM_BYTES(MEM_BYTES), .WAIT_STATES(0), .INIT_FILE(""))
    dut0 (.clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
  riscv_ahb_code_rom_slave #(.BASE_ADDR(BASE_A), .MEM_BYTES(MEM_BYTES), .WAIT_STATES(2), .INIT_FILE(""))
    dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
  riscv_ahb_code_rom_slave #(.BASE_ADDR(BASE_C), .MEM_BYTES(MEM_BYTES), .WAIT_STATES(3), .INIT_FILE(""))
    dut2 (.clk(clk), .rst(rst), .bus(bus2), .state_dbg(st2));

  always_comb begin
    o_ready = bus0.hreadyout; o_resp = bus0.hresp; o_data = bus0.hrdata; o_state = st0;
    case (sel)
      1: begin o_ready = bus1.hreadyout; o_resp = bus1.hresp; o_data = bus1.hrdata; o_state = st1; end
      2: begin o_ready = bus2.hreadyout; o_resp = bus2.hresp; o_data = bus2.hrdata; o_state = st2; end
      default: ;
    endcase
  end

  function automatic int ws_of(input int s);
    case (s)
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int s);
    return (s == 2) ? BASE_C : BASE_A;
  endfunction

  // Reference model: per-cycle {hreadyout, hresp, hrdata} the data phase of one accepted transfer shows.
  task automatic model_push(input logic [31:0] a, input logic w, input logic [2:0] sz);
    logic [31:0] off;
    logic        err;
    off = a - base_of(sel);
    err = w || (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
          (off >= 32'(MEM_BYTES));
    if (err) begin
      exp_q.push_back({2'b01, 32'h0});
      exp_q.push_back({2'b11, 32'h0});
    end else begin
      for (int i = 0; i < ws_of(sel); i++) exp_q.push_back(34'h0);
      exp_q.push_back({2'b10, rom_model[int'(off >> 2)]});
    end
  endtask

  // scoreboard: compare the active slave's outputs with the model once per cycle
  task automatic step_check(input string tag);
    logic [33:0] e, o;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_idle = 1'b0;
    end else begin
      e = {2'b10, 32'h0};
      last_idle = 1'b1;
    end
    o = {o_ready, o_resp, o_data};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s sel=%0d t=%0t got ready=%b resp=%b data=%h, expected ready=%b resp=%b data=%h",
               tag, sel, $time, o[33], o[32], o[31:0], e[33], e[32], e[31:0]);
    end
  endtask

  // driver tasks
  task automatic drive_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    hsel = 1'b1; hready = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
    model_push(a, w, sz);
  endtask

  task automatic drive_idle();
    haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom_range(0, 3));
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
    hsel = 1'($urandom);
    if (exp_q.size() != 0) begin
      hready = 1'b0;
      htrans = 2'($urandom);
    end else begin
      hready = 1'b1;
      htrans = hsel ? {1'b0, 1'($urandom)} : 2'($urandom);
    end
  endtask

  task automatic drive_stall();
    hsel = 1'b1; hready = 1'b0; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD;
    haddr = base_of(sel) + 32'd4;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr,
                      input string tag);
    step_check(tag);
    while (exp_q.size() != 0) begin
      drive_idle();
      step_check(tag);
    end
    drive_xfer(a, w, sz, tr);
  endtask

  task automatic drain(input string tag);
    step_check(tag);
    while (exp_q.size() != 0) begin
      drive_idle();
      step_check(tag);
    end
    drive_idle();
  endtask

  task automatic test_reset_state();
    #2;
    n_checks++;
    if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_state dut0 got %b %b %h, expected 1 0 0", bus0.hreadyout, bus0.hresp, bus0.hrdata);
    end
    n_checks++;
    if ({bus1.hreadyout, bus1.hresp, bus1.hrdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_state dut1 got %b %b %h, expected 1 0 0", bus1.hreadyout, bus1.hresp, bus1.hrdata);
    end
    n_checks++;
    if ({bus2.hreadyout, bus2.hresp, bus2.hrdata} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_state dut2 got %b %b %h, expected 1 0 0", bus2.hreadyout, bus2.hresp, bus2.hrdata);
    end
  endtask

  task automatic test_reset();
    sel = 2;
    xfer(BASE_C + 32'd8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "reset_pre");
    step_check("reset_wait1");
    drive_idle();
    step_check("reset_wait2");
    drive_idle();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_ready, o_resp, o_data} !== {2'b10, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid_wait got %b %b %h, expected 1 0 0", o_ready, o_resp, o_data);
    end
    n_checks++;
    if (o_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_wait_state got %0d, expected 0", o_state);
    end
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    drive_idle();
    step_check("reset_after");
    n_checks++;
    if (o_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_after_state got %0d, expected 0", o_state);
    end
    drive_idle();
  endtask

  task automatic test_single_read();
    sel = 0;
    xfer(32'h4, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "single_read");
    drain("single_read");
  endtask

  task automatic test_back_to_back();
    sel = 1;
    xfer(32'h0, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "b2b_first");
    xfer(32'h4, 1'b0, HSIZE_WORD, HTRANS_SEQ, "b2b_second");
    drain("b2b_drain");
  endtask

  task automatic test_write_error();
    sel = 0;
    xfer(32'h8, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, "write_err");
    xfer(32'h8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "read_after_write");
    drain("write_drain");
  endtask

  task automatic test_error_cases();
    sel = 0;
    xfer(BASE_A + 32'(MEM_BYTES), 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "err_range");
    xfer(32'h2, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "err_misaligned");
    xfer(32'h0, 1'b0, 3'd3, HTRANS_NONSEQ, "err_size");
    xfer(32'h2, 1'b0, HSIZE_HALF, HTRANS_NONSEQ, "half_ok");
    drain("err_drain");
    sel = 2;
    xfer(BASE_C - 32'd4, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, "err_below_base");
    xfer(BASE_C + 32'(MEM_BYTES) - 32'd1, 1'b0, HSIZE_BYTE, HTRANS_NONSEQ, "last_byte_ok");
    drain("err_drain2");
  endtask

  task automatic test_no_accept();
    sel = 0;
    drain("noacc_pre");
    step_check("noacc_pre2");
    hsel = 1'b1; hready = 1'b1; htrans = HTRANS_IDLE; haddr = 32'h4; hwrite = 1'b0; hsize = HSIZE_WORD;
    step_check("noacc_idle");
    htrans = HTRANS_BUSY;
    step_check("noacc_busy");
    drive_stall();
    step_check("noacc_stall");
    n_checks++;
    if (o_state !== 3'd0) begin
      n_fail++; $display("FAIL noacc_state got %0d, expected 0", o_state);
    end
    drive_idle();
  endtask

  task automatic test_random(input int s, input int n);
    logic [31:0] off;
    logic [2:0]  sz;
    int          r;
    sel = s;
    for (int k = 0; k < n; k++) begin
      step_check("random");
      if (exp_q.size() != 0) begin
        drive_idle();
      end else begin
        r = $urandom_range(0, 19);
        if (r < 3) begin
          drive_idle();
        end else if (r == 3) begin
          if (last_idle) drive_stall();
          else drive_idle();
        end else begin
          sz  = (r == 4) ? 3'd3 : 3'($urandom_range(0, 2));
          off = 32'($urandom_range(0, MEM_BYTES - 1));
          if (r > 7) off = off & ~32'((1 << sz) - 1);
          if (r == 6) off = $urandom_range(0, 1) ? 32'(MEM_BYTES) + 32'($urandom_range(0, 64))
                                                 : 32'h0 - 32'($urandom_range(1, 16));
          drive_xfer(base_of(sel) + off, (r == 5), sz, $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ);
        end
      end
    end
    drain("random_drain");
  endtask

  initial begin
    n_checks = 0; n_fail = 0; last_idle = 1'b1; sel = 0;
    rst = 1'b1; hsel = 1'b0; hready = 1'b1; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = '0; hprot = '0; hmastlock = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom_model[i] = $urandom;
    rom_model[1] = 32'hDEADBEEF;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      dut0.u_rom.mem[i] = rom_model[i];
      dut1.u_rom.mem[i] = rom_model[i];
      dut2.u_rom.mem[i] = rom_model[i];
    end
    test_reset_state();
    @(negedge clk) rst = 1'b0;
    drive_idle();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_error();
    test_error_cases();
    test_no_accept();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
